// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//
// Shared definitions for the tick-driven PWM generator.
//   - pwm_state_t    : controller state encoding (IDLE / RUN / DRAIN).
//   - CNT_W_DEFAULT  : default width of the period, duty and tick counter.
//
// Build option (consumed by tick_edge_det, listed here for reference):
//   TICK_SYNC_EN - when defined, div_in goes through a 2-flop synchronizer
//                  before edge detection (tick latency 3 clk instead of 1).
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no waveform, counter parked at 0, pwm_out low
        RUN   = 2'd1,   // counting ticks, waveform active
        DRAIN = 2'd2    // enable dropped; finish the current period, then stop
    } pwm_state_t;

endpackage

// File: rtl/tick_edge_det.sv
// -----------------------------------------------------------------------------
// tick_edge_det
//
// Turns each rising edge of the divided clock into a single-cycle tick.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high
//   div_in in   divided clock from the clock divider
//   tick   out  registered one-cycle pulse per div_in rising edge
//
// Build option:
//   TICK_SYNC_EN - defined  : div_in passes through a 2-flop synchronizer, so
//                             it may be asynchronous to clk; the tick appears
//                             3 clk after the div_in rise.
//                  undefined: div_in is sampled directly (same clk domain);
//                             the tick appears 1 clk after the div_in rise.
// -----------------------------------------------------------------------------
module tick_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic div_in,
    output logic tick
);

    logic div_s;    // div_in as seen by the edge detector
    logic div_q;    // previous sample of div_s

`ifdef TICK_SYNC_EN
    // Shift-register synchronizer: sync_pipe[0] is the metastability-catching
    // flop, sync_pipe[1] is the settled copy used by the edge detector.
    logic [1:0] sync_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], div_in};
        end
    end

    assign div_s = sync_pipe[1];
`else
    assign div_s = div_in;
`endif

    // Rising-edge detector. A level that stays high produces only the first
    // pulse because div_q follows it one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
            tick  <= 1'b0;
        end else begin
            div_q <= div_s;
            tick  <= div_s & ~div_q;
        end
    end

endmodule

// File: rtl/tick_pwm_gen.sv
// -----------------------------------------------------------------------------
// tick_pwm_gen
//
// PWM generator clocked by ticks derived from the clock divider output.
// Period and duty (both in ticks) arrive over a valid/ready port into a
// shadow register pair and are promoted to the active pair only at a period
// boundary (or right away while idle), so the waveform never tears.
//
// Parameters:
//   CNT_W      width of period, duty and the tick counter
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   div_in     in   divided clock (same clk domain unless TICK_SYNC_EN)
//   enable     in   level request for PWM generation
//   cfg_valid  in   config offer
//   cfg_ready  out  shadow slot free (no config pending)
//   cfg_period in   period in ticks (0 behaves as 1)
//   cfg_duty   in   high time in ticks (0 = always low, >= period = always high)
//   tick       out  one-cycle pulse per div_in rising edge
//   pwm_out    out  registered PWM waveform
//   cycle_done out  one-cycle pulse, coincident with the wrap tick
//   busy       out  controller not in IDLE
//
// Build option:
//   TICK_SYNC_EN - adds a 2-flop synchronizer on div_in (see tick_edge_det).
// -----------------------------------------------------------------------------
module tick_pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             tick,
    output logic             pwm_out,
    output logic             cycle_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_t       state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sh_period, sh_duty;     // shadow (written by the port)
    logic [CNT_W-1:0] act_period, act_duty;   // active (used by the counter)
    logic             pending;                // shadow holds an unapplied config
    logic             cfg_loaded;             // active pair is valid since reset
    logic             started;                // first tick of this run seen

    logic [CNT_W-1:0] per_eff;
    logic             at_end;
    logic             wrap;
    logic             apply;
    logic             cfg_xfer;
    logic [CNT_W-1:0] cnt_adv;
    logic [CNT_W-1:0] duty_nxt;

    // -------------------------------------------------------------------------
    // Tick generation
    // -------------------------------------------------------------------------
    tick_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .div_in (div_in),
        .tick   (tick)
    );

    // -------------------------------------------------------------------------
    // Counter datapath
    // -------------------------------------------------------------------------
    // A zero period would make period-1 underflow; treat it as one tick.
    assign per_eff  = (act_period == '0) ? ONE : act_period;

    // The counter only means something once the first tick of a run has
    // parked it at 0; before that no tick can be a wrap.
    assign at_end   = started && (cnt == per_eff - ONE);
    assign wrap     = tick && (state != IDLE) && at_end;

    // A transfer is only accepted while nothing is pending, so a transfer and
    // an apply can never happen in the same cycle. A transfer landing on a
    // wrap therefore only reaches the shadow and waits for the next wrap.
    assign cfg_xfer = cfg_valid && !pending;
    assign apply    = pending && ((state == IDLE) || wrap);

    // First tick of a run starts the count at 0; later ticks advance/wrap.
    assign cnt_adv  = !started ? '0 : (at_end ? '0 : cnt + ONE);

    // The wrap tick opens the next period, so it must already compare against
    // the duty that is being promoted on that same tick.
    assign duty_nxt = (wrap && pending) ? sh_duty : act_duty;

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable && cfg_loaded) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Re-enable resumes the same period without restarting it.
                // A run that never saw a tick has no period to finish.
                if (enable) begin
                    state_nxt = RUN;
                end else if (!started || wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Config double buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_period  <= '0;
            sh_duty    <= '0;
            act_period <= '0;
            act_duty   <= '0;
            pending    <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            if (apply) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
                pending    <= 1'b0;
                cfg_loaded <= 1'b1;
            end
            if (cfg_xfer) begin
                sh_period <= cfg_period;
                sh_duty   <= cfg_duty;
                pending   <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counter and waveform
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
            started <= 1'b0;
        end else if (state_nxt == IDLE) begin
            // Covers sitting in IDLE and the DRAIN exit on the wrap tick.
            cnt     <= '0;
            pwm_out <= 1'b0;
            started <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            cnt     <= cnt_adv;
            pwm_out <= (cnt_adv < duty_nxt);
            started <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg_ready  = ~pending;
    assign busy       = (state != IDLE);
    assign cycle_done = wrap;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_tick_pwm_gen
//
// Directed bench for tick_pwm_gen. Each generated tick pushes the expected
// {pwm_out, cycle_done} pair onto a scoreboard; a negedge monitor captures
// cycle_done in the tick cycle and pwm_out one cycle later, pops the queue
// and compares. Expected patterns are written per tick, LSB = first tick.
// -----------------------------------------------------------------------------
module tb_tick_pwm_gen;

`ifdef TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       div_in;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       tick;
    logic       pwm_out;
    logic       cycle_done;
    logic       busy;

    typedef struct packed {
        logic pwm;
        logic cd;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   track    = 1'b0;
    bit   chk_pend = 1'b0;
    logic cd_s;
    int   tick_no  = 0;

    tick_pwm_gen #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_in     (div_in),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .tick       (tick),
        .pwm_out    (pwm_out),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (track && !reset) begin
            if (chk_pend) begin
                chk_pend = 1'b0;
                chk($sformatf("sb_nonempty t%0d", tick_no), (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("pwm_out t%0d", tick_no), pwm_out, e.pwm);
                    chk($sformatf("cycle_done t%0d", tick_no), cd_s, e.cd);
                end
                tick_no++;
            end
            if (tick) begin
                chk_pend = 1'b1;
                cd_s     = cycle_done;
            end
        end
    end

    // One div_in period of 4 clk; entered and left at posedge+1.
    task automatic do_tick();
        div_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        div_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic play(input int n, input logic [31:0] pw, input logic [31:0] cd);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.pwm = pw[i];
            x.cd  = cd[i];
            sb.push_back(x);
            do_tick();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] p, input logic [7:0] d);
        chk("cfg_ready_before_send", cfg_ready, 1);
        cfg_period = p;
        cfg_duty   = d;
        cfg_valid  = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
    endtask

    initial begin
        int first;
        int nt;

        reset      = 1'b1;
        div_in     = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cycle_done", cycle_done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Tick latency and single tick for a long high level.
        first  = -1;
        nt     = 0;
        div_in = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tick) begin
                nt++;
                if (first < 0) first = i;
            end
            if (i == 10) div_in = 1'b0;
        end
        chk("tick_latency", first, LAT);
        chk("tick_count_long_high", nt, 1);
        repeat (3) @(posedge clk);
        #1;
        track = 1'b1;

        // Period 4, duty 1.
        send_cfg(8'd4, 8'd1);
        chk("cfg_ready_after_xfer", cfg_ready, 0);
        @(posedge clk);
        #1;
        chk("cfg_ready_idle_reload", cfg_ready, 1);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_run", busy, 1);
        play(9, 32'h111, 32'h110);

        // Mid-period reconfig to period 5, duty 3.
        play(1, 32'h0, 32'h0);
        send_cfg(8'd5, 8'd3);
        chk("cfg_ready_pending", cfg_ready, 0);
        play(2, 32'h0, 32'h0);
        chk("cfg_ready_hold_to_wrap", cfg_ready, 0);
        play(1, 32'h1, 32'h1);
        chk("cfg_ready_after_wrap", cfg_ready, 1);
        play(5, 32'h13, 32'h10);

        // Duty 0 at period 4.
        send_cfg(8'd4, 8'd0);
        play(4, 32'h3, 32'h0);
        play(8, 32'h0, 32'h11);

        // Duty 9 beyond period 8.
        send_cfg(8'd8, 8'd9);
        play(9, 32'h1FF, 32'h101);

        // Period 0 behaves as 1.
        send_cfg(8'd0, 8'd0);
        play(7, 32'h7F, 32'h0);
        play(4, 32'h0, 32'hF);

        // Drain: drop enable at cnt=1 of period 4.
        send_cfg(8'd4, 8'd1);
        play(2, 32'h1, 32'h1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_drain", busy, 1);
        play(3, 32'h0, 32'h4);
        chk("busy_after_drain", busy, 0);
        chk("pwm_after_drain", pwm_out, 0);
        play(1, 32'h0, 32'h0);
        chk("busy_idle_tick", busy, 0);

        // Re-enable during drain keeps counting.
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_restart", busy, 1);
        play(2, 32'h1, 32'h0);
        enable = 1'b0;
        play(1, 32'h0, 32'h0);
        chk("busy_drain2", busy, 1);
        enable = 1'b1;
        play(3, 32'h2, 32'h2);
        chk("busy_reassert", busy, 1);

        // Asynchronous reset while pwm_out is high.
        play(3, 32'h4, 32'h4);
        chk("pwm_pre_reset", pwm_out, 1);
        track = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pwm_out", pwm_out, 0);
        chk("async_rst_tick", tick, 0);
        chk("async_rst_cycle_done", cycle_done, 0);
        chk("async_rst_cfg_ready", cfg_ready, 1);
        chk("async_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_no_cfg", busy, 0);
        do_tick();
        repeat (2) @(posedge clk);
        #1;
        chk("busy_no_cfg_tick", busy, 0);
        chk("pwm_no_cfg_tick", pwm_out, 0);

        // Fresh config after reset: period 3, duty 2.
        track = 1'b1;
        send_cfg(8'd3, 8'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("busy_new_cfg", busy, 1);
        play(4, 32'hB, 32'h8);

        repeat (4) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
